// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing the 8:1 bit-select multiplexer among eight requesters.
// Drives the mux address, holds a one-hot grant and captures the returned bit with its source index.
module mux_rr_scheduler #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_req,
    input  logic       i_mux_out,
    output logic [2:0] o_address,
    output logic [7:0] o_grant,
    output logic       o_busy,
    output logic       o_bit_out,
    output logic       o_bit_valid,
    output logic [2:0] o_bit_src
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
    localparam bit         BURST_EN    = (MAX_BURST != 0);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t     r_state;
    logic [2:0] r_last;
    logic [2:0] r_cur;
    logic [7:0] r_burstCnt;
    logic [2:0] r_address;
    logic [7:0] r_grant;
    logic       r_bitOut;
    logic       r_bitValid;
    logic [2:0] r_bitSrc;

    logic [2:0] w_searchBase;
    logic [3:0] w_search;
    logic       w_found;
    logic [2:0] w_winner;
    logic [7:0] w_curMask;
    logic       w_competitor;
    logic       w_release;

    // Scan base+1 upward with wrap; base itself is checked last so it has lowest priority.
    function automatic logic [3:0] findWinner(input logic [7:0] req, input logic [2:0] base);
        logic       found;
        logic [2:0] winner;
        logic [2:0] idx;
        found  = 1'b0;
        winner = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = base + 3'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        return {found, winner};
    endfunction

    // On a release the freshly served index becomes the new search base on the same edge.
    assign w_searchBase = (r_state == ST_GRANT) ? r_cur : r_last;
    assign w_search     = findWinner(i_req, w_searchBase);
    assign w_found      = w_search[3];
    assign w_winner     = w_search[2:0];

    assign w_curMask    = 8'b1 << r_cur;
    assign w_competitor = |(i_req & ~w_curMask);
    assign w_release    = (r_state == ST_GRANT) &&
                          (!i_req[r_cur] ||
                           (BURST_EN && (r_burstCnt >= BURST_LIMIT) && w_competitor));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 3'd7;
            r_cur      <= 3'd0;
            r_burstCnt <= 8'd0;
            r_address  <= 3'd0;
            r_grant    <= 8'd0;
            r_bitOut   <= 1'b0;
            r_bitValid <= 1'b0;
            r_bitSrc   <= 3'd0;
        end else begin
            // One sample per cycle the grant was held, taken from the address in use.
            if (r_grant != 8'd0) begin
                r_bitOut   <= i_mux_out;
                r_bitSrc   <= r_address;
                r_bitValid <= 1'b1;
            end else begin
                r_bitValid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_cur      <= w_winner;
                        r_address  <= w_winner;
                        r_grant    <= 8'b1 << w_winner;
                        r_burstCnt <= 8'd1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_last <= r_cur;
                        if (w_found) begin
                            r_cur      <= w_winner;
                            r_address  <= w_winner;
                            r_grant    <= 8'b1 << w_winner;
                            r_burstCnt <= 8'd1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= 8'd0;
                        end
                    end else if (r_burstCnt != 8'hFF) begin
                        r_burstCnt <= r_burstCnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 8'd0;
                end
            endcase
        end
    end

    assign o_address   = r_address;
    assign o_grant     = r_grant;
    assign o_busy      = |r_grant;
    assign o_bit_out   = r_bitOut;
    assign o_bit_valid = r_bitValid;
    assign o_bit_src   = r_bitSrc;

endmodule
